// File: rtl/sw_debounce_pkg.sv
// Board-level constants shared by the switch conditioner and the LED top.
// Widths and the 1 ms debounce window at 50 MHz.
package sw_debounce_pkg;

    localparam int SW_WIDTH           = 8;
    localparam int LED_WIDTH          = 6;
    localparam int DEBOUNCE_1MS_50MHZ = 50000;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, stability counter, clean level,
// registered rise/fall strobes and a toggle that flips on every rise.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int N = DEBOUNCE_1MS_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall,
    output logic o_toggle
);

    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_rise;
    logic             r_fall;
    logic             r_toggle;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1   <= i_sw;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // any return to the accepted level restarts the full window
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt    <= '0;
                r_stable <= r_s2;
                r_rise   <= r_s2;
                r_fall   <= ~r_s2;
                if (r_s2)
                    r_toggle <= ~r_toggle;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_toggle = r_toggle;

endmodule

// File: rtl/sw_debounce.sv
// Conditions WIDTH raw slide switches into clean levels, edge strobes
// and per-bit toggles; any_change flags a strobe on any bit.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] sw_toggle,
    output logic             any_change
);

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            debounce_bit #(
                .N (DEBOUNCE_CYCLES)
            ) u_bit (
                .clk      (clk),
                .rst      (rst),
                .i_sw     (sw[g]),
                .o_stable (sw_stable[g]),
                .o_rise   (sw_rise[g]),
                .o_fall   (sw_fall[g]),
                .o_toggle (sw_toggle[g])
            );
        end
    endgenerate

    assign any_change = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus random switch activity,
// every cycle compared against a window-based reference model.
module tb_sw_debounce;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw  = '0;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic [W-1:0] sw_toggle;
    logic         any_change;

    int n_chk  = 0;
    int n_fail = 0;

    sw_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_toggle  (sw_toggle),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: sync is two plain delays; a bit flips once the last N
    // synchronised samples since its previous flip all disagree with it.
    logic [W-1:0] m_s1, m_s2, m_st, m_rise, m_fall, m_tog;
    logic [W-1:0] uq[$];
    int           since[W];

    task automatic model_edge();
        logic [W-1:0] used;
        bit ok;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0;
            m_rise = '0; m_fall = '0; m_tog = '0;
            uq.delete();
            for (int b = 0; b < W; b++) since[b] = 0;
        end else begin
            used = m_s2;
            m_s2 = m_s1;
            m_s1 = sw;
            uq.push_back(used);
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) begin
                if (uq.size() - since[b] >= N) begin
                    ok = 1'b1;
                    for (int t = uq.size() - N; t < uq.size(); t++)
                        if (uq[t][b] == m_st[b]) ok = 1'b0;
                    if (ok) begin
                        m_st[b] = ~m_st[b];
                        if (m_st[b]) begin
                            m_rise[b] = 1'b1;
                            m_tog[b]  = ~m_tog[b];
                        end else begin
                            m_fall[b] = 1'b1;
                        end
                        since[b] = uq.size();
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("stable", 32'(sw_stable), 32'(m_st));
        chk("rise",   32'(sw_rise),   32'(m_rise));
        chk("fall",   32'(sw_fall),   32'(m_fall));
        chk("toggle", 32'(sw_toggle), 32'(m_tog));
        chk("any",    32'(any_change), 32'(|(m_rise | m_fall)));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // edges until sw_rise[b] fires, -1 if it never does within 20
    task automatic edges_to_rise(input int b, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (sw_rise[b]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [W-1:0] v);
        sw  = v;
        rst = 1'b1;
        steps(3);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int ev[$];
        bit seen3;

        // 1: switches high through reset
        sw  = 8'hFF;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out", 32'({sw_stable, sw_rise, sw_fall, sw_toggle,
                                any_change}), 32'(0));
        end
        rst = 1'b0;
        edges_to_rise(0, n);
        chk("t1_lat", 32'(n), 32'(6));
        chk("t1_rise", 32'(sw_rise), 32'(8'hFF));
        chk("t1_any", 32'(any_change), 32'(1));
        step();
        chk("t1_rise_off", 32'(sw_rise), 32'(0));

        // 2: single press on bit 0
        do_reset(8'h00);
        steps(4);
        sw[0] = 1'b1;
        edges_to_rise(0, n);
        chk("t2_lat", 32'(n), 32'(6));
        chk("t2_st0", 32'(sw_stable[0]), 32'(1));
        step();
        chk("t2_rise_off", 32'(sw_rise[0]), 32'(0));
        chk("t2_tog", 32'(sw_toggle[0]), 32'(1));

        // 3: 3-cycle glitch on bit 3 is never accepted
        seen3 = 1'b0;
        sw[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            seen3 |= sw_rise[3] | sw_fall[3] | sw_stable[3];
        end
        sw[3] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen3 |= sw_rise[3] | sw_fall[3] | sw_stable[3];
        end
        chk("t3_glitch", 32'(seen3), 32'(0));

        // 4: bounce 1,0 then held high on bit 5
        sw[5] = 1'b1;
        step();
        sw[5] = 1'b0;
        step();
        sw[5] = 1'b1;
        edges_to_rise(5, n);
        chk("t4_lat", 32'(n), 32'(6));

        // 5: press/release twice on bit 0
        do_reset(8'h00);
        steps(4);
        for (int p = 0; p < 4; p++) begin
            sw[0] = (p % 2 == 0);
            for (int i = 0; i < 10; i++) begin
                step();
                if (sw_rise[0]) ev.push_back(1);
                if (sw_fall[0]) ev.push_back(2);
            end
            if (p == 0) chk("t5_tog1", 32'(sw_toggle[0]), 32'(1));
            if (p == 2) chk("t5_tog0", 32'(sw_toggle[0]), 32'(0));
        end
        chk("t5_nev", 32'(ev.size()), 32'(4));
        for (int i = 0; i < ev.size() && i < 4; i++)
            chk("t5_order", 32'(ev[i]), 32'((i % 2 == 0) ? 1 : 2));

        // 6: reset lands mid-count of a rise on bit 7
        do_reset(8'h00);
        steps(4);
        sw[7] = 1'b1;
        steps(4);
        rst = 1'b1;
        steps(2);
        chk("t6_rst", 32'({sw_stable, sw_rise, sw_toggle}), 32'(0));
        rst = 1'b0;
        edges_to_rise(7, n);
        chk("t6_lat", 32'(n), 32'(6));

        // random activity with occasional reset
        for (int k = 0; k < 400; k++) begin
            sw  = sw ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            rst = ($urandom_range(0, 60) == 0);
            steps($urandom_range(1, 9));
        end
        rst = 1'b0;
        steps(10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
